// File: rtl/spu_pkg.sv
// spu_pkg: opcodes and command/result types shared by the TinySPU sequencer.
package spu_pkg;
    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_MUL     = 4'd3,
        OP_AND     = 4'd4,
        OP_OR      = 4'd5,
        OP_XOR     = 4'd6,
        OP_NOT     = 4'd7,
        OP_SHL     = 4'd8,
        OP_SHR     = 4'd9,
        OP_MIN     = 4'd10,
        OP_MAX     = 4'd11,
        OP_ABS     = 4'd12,
        OP_CMP     = 4'd13,
        OP_MAC     = 4'd14,
        OP_DOTPROD = 4'd15
    } spu_op_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic       chain;
    } spu_cmd_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] m;
        logic [3:0] n;
    } spu_res_t;
endpackage

// File: rtl/spu_seq_fifo.sv
// spu_seq_fifo: W-bit, D-entry (power of 2) FIFO with registered occupancy count.
module spu_seq_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [W-1:0]         i_data,
    input  logic                 i_pop,
    output logic [W-1:0]         o_data,
    output logic [$clog2(D):0]   o_count
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rp];
    assign o_count = r_cnt;
endmodule

// File: rtl/spu_sequencer.sv
// spu_sequencer: credit-limited command scheduler in front of the fixed-latency TinySPU.
// Define SPU_SEQ_CHAIN_EN to let a command take A/B from the previous result.
module spu_sequencer
    import spu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int SPU_LAT   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_c,
    input  logic [3:0] cmd_d,
    input  logic       cmd_chain,
    output logic [3:0] spu_op,
    output logic [3:0] spu_a,
    output logic [3:0] spu_b,
    output logic [3:0] spu_c,
    output logic [3:0] spu_d,
    input  logic [3:0] spu_m,
    input  logic [3:0] spu_n,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_m,
    output logic [3:0] res_n,
    output logic [3:0] res_op,
    output logic       busy
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
`ifdef SPU_SEQ_CHAIN_EN
    localparam int CW = $bits(spu_cmd_t);
`else
    localparam int CW = $bits(spu_cmd_t) - 1;
`endif

    logic [CW-1:0]      w_cmd_in, w_cmd_out;
    logic [CAW:0]       w_cmd_cnt;
    logic [RAW:0]       w_res_cnt, r_inflight;
    spu_cmd_t           w_head;
    spu_res_t           w_res_in, w_res_out;
    logic               w_push, w_issue, w_stall, w_credit, w_cap, w_pop, r_iv;
    logic [3:0]         w_a, w_b;
    logic [SPU_LAT-1:0] r_vld;
    logic [3:0]         r_tag [SPU_LAT];

`ifdef SPU_SEQ_CHAIN_EN
    logic [3:0] r_last_m, r_last_n;
    assign w_cmd_in = {cmd_op, cmd_a, cmd_b, cmd_c, cmd_d, cmd_chain};
    assign w_head   = w_cmd_out;
    assign w_stall  = w_head.chain && r_inflight != '0;
    assign w_a      = w_head.chain ? r_last_m : w_head.a;
    assign w_b      = w_head.chain ? r_last_n : w_head.b;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_m <= '0;
            r_last_n <= '0;
        end else if (w_cap) begin
            r_last_m <= spu_m;
            r_last_n <= spu_n;
        end
    end
`else
    logic w_unused;
    assign w_cmd_in = {cmd_op, cmd_a, cmd_b, cmd_c, cmd_d};
    assign w_head   = spu_cmd_t'({w_cmd_out, 1'b0});
    assign w_stall  = 1'b0;
    assign w_a      = w_head.a;
    assign w_b      = w_head.b;
    assign w_unused = cmd_chain ^ w_head.chain;
`endif

    // Credit covers every op between issue and result pop, so the result FIFO cannot overflow.
    assign cmd_ready = w_cmd_cnt != (CAW+1)'(CMD_DEPTH);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_credit  = ({1'b0, r_inflight} + {1'b0, w_res_cnt}) < (RAW+2)'(RES_DEPTH);
    assign w_issue   = w_cmd_cnt != '0 && w_credit && !w_stall;
    assign w_cap     = r_vld[SPU_LAT-1];
    assign w_res_in  = '{op: r_tag[SPU_LAT-1], m: spu_m, n: spu_n};
    assign res_valid = w_res_cnt != '0;
    assign w_pop     = res_valid && res_ready;
    assign {res_op, res_m, res_n} = res_valid ? w_res_out : '0;
    assign busy      = w_cmd_cnt != '0 || r_inflight != '0 || res_valid;

    spu_seq_fifo #(.W(CW), .D(CMD_DEPTH)) u_cmd (
        .clk(clk), .rst_n(rst_n), .i_push(w_push), .i_data(w_cmd_in),
        .i_pop(w_issue), .o_data(w_cmd_out), .o_count(w_cmd_cnt)
    );

    spu_seq_fifo #(.W($bits(spu_res_t)), .D(RES_DEPTH)) u_res (
        .clk(clk), .rst_n(rst_n), .i_push(w_cap), .i_data(w_res_in),
        .i_pop(w_pop), .o_data(w_res_out), .o_count(w_res_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spu_op     <= '0;
            spu_a      <= '0;
            spu_b      <= '0;
            spu_c      <= '0;
            spu_d      <= '0;
            r_iv       <= 1'b0;
            r_vld      <= '0;
            r_inflight <= '0;
        end else begin
            spu_op     <= w_issue ? w_head.op : '0;
            spu_a      <= w_issue ? w_a : '0;
            spu_b      <= w_issue ? w_b : '0;
            spu_c      <= w_issue ? w_head.c : '0;
            spu_d      <= w_issue ? w_head.d : '0;
            r_iv       <= w_issue;
            r_vld      <= (r_vld << 1) | SPU_LAT'(r_iv);
            r_inflight <= r_inflight + (RAW+1)'(w_issue) - (RAW+1)'(w_cap);
        end
    end

    always_ff @(posedge clk) begin
        r_tag[0] <= spu_op;
        for (int k = 1; k < SPU_LAT; k++) r_tag[k] <= r_tag[k-1];
    end

    a_res_room: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_cap && w_res_cnt == (RAW+1)'(RES_DEPTH)));
endmodule

// File: tb/tb_spu_sequencer.sv
// tb_spu_sequencer: directed bench for spu_sequencer against a 2-cycle SPU stub (M=A+B, N=C^D).
module tb_spu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, cmd_ready, cmd_chain, res_valid, res_ready, busy;
    logic [3:0] cmd_op, cmd_a, cmd_b, cmd_c, cmd_d;
    logic [3:0] spu_op, spu_a, spu_b, spu_c, spu_d, spu_m, spu_n;
    logic [3:0] res_m, res_n, res_op;
    logic [3:0] s1_m, s1_n, s2_m, s2_n;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s1_m <= spu_a + spu_b;
        s1_n <= spu_c ^ spu_d;
        s2_m <= s1_m;
        s2_n <= s1_n;
    end
    assign spu_m = s2_m;
    assign spu_n = s2_n;

    spu_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(4), .SPU_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
        .cmd_chain(cmd_chain), .spu_op(spu_op), .spu_a(spu_a), .spu_b(spu_b),
        .spu_c(spu_c), .spu_d(spu_d), .spu_m(spu_m), .spu_n(spu_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_m(res_m), .res_n(res_n),
        .res_op(res_op), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, a, b, c, d, input logic ch);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_c = c;
        cmd_d = d;
        cmd_chain = ch;
    endtask

    task automatic do_reset;
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if ({spu_op, spu_a, spu_b, spu_c, spu_d} !== 20'h0) begin
            failures++; $display("FAIL reset_spu got=%h exp=00000", {spu_op, spu_a, spu_b, spu_c, spu_d});
        end
        checks++;
        if ({res_op, res_m, res_n} !== 12'h0) begin
            failures++; $display("FAIL reset_res got=%h exp=000", {res_op, res_m, res_n});
        end
    endtask

    task automatic test_single;
        do_reset;
        res_ready = 1'b0;
        drive(4'd5, 4'd3, 4'd4, 4'd6, 4'd5, 1'b0);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", cmd_ready); end
        tick;
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        tick;
        checks++;
        if ({spu_op, spu_a, spu_b, spu_c, spu_d} !== 20'h53465) begin
            failures++; $display("FAIL single_spu got=%h exp=53465", {spu_op, spu_a, spu_b, spu_c, spu_d});
        end
        tick;
        tick;
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", res_valid); end
        tick;
        checks++;
        if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", res_valid); end
        checks++;
        if ({res_op, res_m, res_n} !== 12'h573) begin
            failures++; $display("FAIL single_res got=%h exp=573", {res_op, res_m, res_n});
        end
        res_ready = 1'b1;
        tick;
        checks++;
        if ({res_valid, busy} !== 2'b00) begin failures++; $display("FAIL single_idle got=%b exp=00", {res_valid, busy}); end
    endtask

    task automatic test_back_to_back;
        logic ev;
        int k;
        do_reset;
        res_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                drive(4'(c + 1), 4'(c), 4'd1, 4'(c), 4'd0, 1'b0);
                checks++;
                if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, cmd_ready); end
            end else cmd_valid = 1'b0;
            ev = (c >= 5 && c <= 8);
            checks++;
            if (res_valid !== ev) begin failures++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, res_valid, ev); end
            if (ev) begin
                k = c - 5;
                checks++;
                if ({res_op, res_m, res_n} !== {4'(k + 1), 4'(k + 1), 4'(k)}) begin
                    failures++; $display("FAIL b2b_res c=%0d got=%h exp=%h", c, {res_op, res_m, res_n}, {4'(k + 1), 4'(k + 1), 4'(k)});
                end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        int acc, n;
        do_reset;
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (acc < 10) begin
                drive(4'(acc), 4'(acc), 4'd2, 4'(acc), 4'hF, 1'b0);
                if (cmd_ready) acc++;
            end else cmd_valid = 1'b0;
            tick;
        end
        cmd_valid = 1'b0;
        checks++;
        if (acc != 8) begin failures++; $display("FAIL bp_accepted got=%0d exp=8", acc); end
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", cmd_ready); end
        checks++;
        if ({res_valid, busy} !== 2'b11) begin failures++; $display("FAIL bp_valid_busy got=%b exp=11", {res_valid, busy}); end
        checks++;
        if (spu_op !== 4'd0) begin failures++; $display("FAIL bp_no_issue got=%h exp=0", spu_op); end
        checks++;
        if ({res_op, res_m, res_n} !== 12'h02F) begin
            failures++; $display("FAIL bp_head got=%h exp=02f", {res_op, res_m, res_n});
        end
        res_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            if (res_valid) begin
                checks++;
                if ({res_op, res_m, res_n} !== {4'(n), 4'(n + 2), 4'(n) ^ 4'hF}) begin
                    failures++; $display("FAIL bp_drain n=%0d got=%h exp=%h", n, {res_op, res_m, res_n}, {4'(n), 4'(n + 2), 4'(n) ^ 4'hF});
                end
                n++;
            end
            tick;
        end
        checks++;
        if (n != 8) begin failures++; $display("FAIL bp_drain_count got=%0d exp=8", n); end
        checks++;
        if ({res_valid, busy} !== 2'b00) begin failures++; $display("FAIL bp_done got=%b exp=00", {res_valid, busy}); end
    endtask

    task automatic test_reset_inflight;
        logic seen;
        do_reset;
        res_ready = 1'b1;
        drive(4'd9, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
        tick;
        cmd_valid = 1'b0;
        tick;
        checks++;
        if (spu_op !== 4'd9) begin failures++; $display("FAIL rst_issue got=%h exp=9", spu_op); end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks++;
        if ({busy, cmd_ready, res_valid, spu_op} !== 7'b0100000) begin
            failures++; $display("FAIL rst_state got=%b exp=0100000", {busy, cmd_ready, res_valid, spu_op});
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (res_valid || busy) seen = 1'b1;
            tick;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_discard got=%b exp=0", seen); end
    endtask

    task automatic test_chain;
        int issue_c, n, exp_c;
        logic [7:0] ab, exp_ab;
        logic [11:0] r0, r1, exp_r1;
        do_reset;
        res_ready = 1'b1;
        issue_c = -1;
        n = 0;
        ab = '0;
        r0 = '0;
        r1 = '0;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) drive(4'd1, 4'd2, 4'd3, 4'd1, 4'd1, 1'b0);
            else if (c == 1) drive(4'd2, 4'd9, 4'd9, 4'd0, 4'd7, 1'b1);
            else cmd_valid = 1'b0;
            if (issue_c < 0 && spu_op == 4'd2) begin
                issue_c = c;
                ab = {spu_a, spu_b};
            end
            if (res_valid) begin
                if (n == 0) r0 = {res_op, res_m, res_n};
                else if (n == 1) r1 = {res_op, res_m, res_n};
                n++;
            end
            tick;
        end
        cmd_chain = 1'b0;
`ifdef SPU_SEQ_CHAIN_EN
        exp_c = 6;
        exp_ab = 8'h50;
        exp_r1 = 12'h257;
`else
        exp_c = 3;
        exp_ab = 8'h99;
        exp_r1 = 12'h227;
`endif
        checks++;
        if (issue_c != exp_c) begin failures++; $display("FAIL chain_issue_cycle got=%0d exp=%0d", issue_c, exp_c); end
        checks++;
        if (ab !== exp_ab) begin failures++; $display("FAIL chain_ab got=%h exp=%h", ab, exp_ab); end
        checks++;
        if (n != 2) begin failures++; $display("FAIL chain_count got=%0d exp=2", n); end
        checks++;
        if (r0 !== 12'h150) begin failures++; $display("FAIL chain_res0 got=%h exp=150", r0); end
        checks++;
        if (r1 !== exp_r1) begin failures++; $display("FAIL chain_res1 got=%h exp=%h", r1, exp_r1); end
    endtask

    task automatic test_simul_push_pop;
        int acc, n;
        do_reset;
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            if (acc < 7) begin
                drive(4'(acc), 4'(acc), 4'd0, 4'd0, 4'(acc), 1'b0);
                if (cmd_ready) acc++;
            end else cmd_valid = 1'b0;
            tick;
        end
        checks++;
        if (acc != 7) begin failures++; $display("FAIL sim_accepted got=%0d exp=7", acc); end
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL sim_ready3 got=%b exp=1", cmd_ready); end
        res_ready = 1'b1;
        checks++;
        if ({res_valid, res_op, res_m, res_n} !== 13'h1000) begin
            failures++; $display("FAIL sim_head got=%h exp=1000", {res_valid, res_op, res_m, res_n});
        end
        tick;
        res_ready = 1'b0;
        drive(4'd7, 4'd7, 4'd0, 4'd0, 4'd7, 1'b0);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL sim_ready_push got=%b exp=1", cmd_ready); end
        tick;
        drive(4'd8, 4'd8, 4'd0, 4'd0, 4'd8, 1'b0);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL sim_ready_kept got=%b exp=1", cmd_ready); end
        checks++;
        if (spu_op !== 4'd4) begin failures++; $display("FAIL sim_issue got=%h exp=4", spu_op); end
        tick;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL sim_full got=%b exp=0", cmd_ready); end
        res_ready = 1'b1;
        n = 1;
        for (int c = 0; c < 50 && n < 9; c++) begin
            if (res_valid) begin
                checks++;
                if ({res_op, res_m, res_n} !== {4'(n), 4'(n), 4'(n)}) begin
                    failures++; $display("FAIL sim_drain n=%0d got=%h exp=%h", n, {res_op, res_m, res_n}, {4'(n), 4'(n), 4'(n)});
                end
                n++;
            end
            tick;
        end
        checks++;
        if (n != 9) begin failures++; $display("FAIL sim_drain_count got=%0d exp=9", n); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        {cmd_op, cmd_a, cmd_b, cmd_c, cmd_d} = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_reset_inflight;
        test_chain;
        test_simul_push_pop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spu_sequencer.md
# spu_sequencer

Command scheduler in front of the TinySPU datapath. It accepts operation commands (Op plus A/B/C/D nibbles) over a valid/ready interface and buffers them in a small FIFO. It issues up to one command per cycle into the fixed-latency SPU, captures each result with its opcode tag, and returns results in order over a second valid/ready interface. Issue is credit-limited, so the result buffer never overflows, and results are never dropped under backpressure.

## Interface
Parameters:
- CMD_DEPTH, 4: command FIFO entries (power of 2, ≥2).
- RES_DEPTH, 4: result FIFO entries (power of 2, ≥2); also the in-flight credit limit.
- SPU_LAT, 2: cycles from SPU inputs stable to SPU outputs valid (TinySPU = 2).

Ports:
- clk, in, 1: single clock, all state on rising edge.
- rst_n, in, 1: reset is synchronous and active-low.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: command FIFO not full.
- cmd_op, in, 4: SPU opcode.
- cmd_a / cmd_b / cmd_c / cmd_d, in, 4 each: operands.
- cmd_chain, in, 1: use the previous result as A/B (only with SPU_SEQ_CHAIN_EN).
- spu_op, out, 4: opcode to the SPU.
- spu_a / spu_b / spu_c / spu_d, out, 4 each: operands to the SPU. All spu_* outputs are registered.
- spu_m / spu_n, in, 4 each: SPU outputs.
- res_valid, out, 1: result available.
- res_ready, in, 1: consumer accepts.
- res_m / res_n, out, 4 each: result nibbles.
- res_op, out, 4: opcode that produced the result.
- busy, out, 1: any FIFO entry or in-flight op exists.

## Operation
- Command FIFO push on cmd_valid && cmd_ready. cmd_ready = (cmd_count != CMD_DEPTH), derived from registered count. No bypass when full.
- Issue condition (evaluated each cycle): cmd FIFO non-empty && (inflight + res_count) < RES_DEPTH && no chain stall.
- On issue: pop the head; register op/a/b/c/d onto spu_*; shift a valid bit plus op tag into an SPU_LAT-deep in-flight pipeline.
- Idle cycles: spu_* driven to 0. The SPU result of that cycle is ignored because its in-flight bit is 0.
- Capture: when the in-flight bit exits the pipeline, write {spu_m, spu_n, tag} into the result FIFO.
- The result FIFO is guaranteed non-full by credit. A write on a full FIFO is an assertion failure.
- Result pop on res_valid && res_ready. res_valid = result FIFO non-empty. res_* are the FIFO head, stable while res_valid && !res_ready.
- Ordering: strict FIFO order, no reordering.
- Simultaneous push and pop on either FIFO in the same cycle are both honoured; count is unchanged.
- Reset (rst_n=0 sampled at an edge): all counts, pointers and in-flight bits clear. spu_* = 0, cmd_ready = 1, res_valid = 0, busy = 0, res_* = 0. In-flight SPU results are discarded, even if they emerge after reset.
- Wrap: pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits.

## Timing
- Command handshake in cycle t → earliest spu_* valid in cycle t+2 → captured at end of cycle t+2+SPU_LAT → res_valid in cycle t+3+SPU_LAT (t+5 for TinySPU).
- Sustained throughput is 1 command/cycle when res_ready is held high.
- Credit check uses the current cycle's res_count. A pop in the same cycle frees credit the following cycle.
- busy falls the cycle after the last result is popped.

## Configuration
- SPU_SEQ_CHAIN_EN defined:
  - A last_m/last_n register (reset 0) updates on every capture.
  - Head command with cmd_chain=1 stalls issue until inflight == 0, then issues with spu_a = last_m, spu_b = last_n.
  - C/D/op come from the command.
- SPU_SEQ_CHAIN_EN undefined:
  - cmd_chain is ignored and not stored.
  - No last register and no stall logic.

## Structure
- Shared package spu_pkg holds:
  - opcode constants (OP_NOP=0 … OP_DOTPROD=15);
  - the typedef spu_cmd_t {op, a, b, c, d, chain};
  - the typedef spu_res_t {op, m, n}.
- One sub-module, spu_seq_fifo, is parameterised on width and depth and instantiated for commands and results.
- Issue, credit and in-flight logic live in the top module.

## Test plan
Bench SPU stub: SPU_LAT=2, M = A+B mod 16, N = C^D.
- Single command op=5, A=3, B=4, C=6, D=5 at cycle 0 → res_valid in cycle 5 with res_m=7, res_n=3, res_op=5.
- Four back-to-back commands, res_ready=1 → four consecutive res_valid cycles with results in order.
- res_ready=0 with 10 commands offered:
  - 4 results buffered, no further issue;
  - cmd FIFO fills to 4 and cmd_ready drops;
  - release res_ready → all 8 accepted results drain in order with none lost.
- Reset asserted 1 cycle after issue of op=9 → no result ever appears; busy=0 and cmd_ready=1 after reset.
- (SPU_SEQ_CHAIN_EN) cmd1 A=2, B=3, C=1, D=1, then cmd2 chain=1, C=0, D=7:
  - cmd2 issues only after cmd1 captured;
  - cmd2 sees spu_a=5, spu_b=0 and yields res_m=5, res_n=7.
- Simultaneous push and pop with the cmd FIFO at 3 entries → count stays 3 and cmd_ready stays 1.
